lane_dispatch_sync: RTL and testbench
=====================================

# lane_dispatch_sync

Parametrised request-broadcast and completion-synchronisation hub between the vector instruction launcher and `NrLane` lanes. Requests are broadcast into per-lane skid FIFOs, so lanes that stall on different cycles no longer block each other. Per-VFU done pulses from the lanes, which may arrive on different cycles, are aggregated into one done pulse per VFU operation. A done pulse is released only after every lane has reported that operation.

## Interface
Parameters:
- `NrLane`, 4, number of lanes (≥1)
- `FifoDepth`, 2, entries per lane request FIFO (power of two, ≥2)
- `ReqWidth`, 64, request payload bits
- `NrVFU`, 4, number of per-lane functional units reported
- `IdWidth`, 3, instruction ID bits
- `DoneDepth`, 4, maximum outstanding unmatched done pulses per lane per VFU (≥1)

Ports:
- `clk_i` in 1: clock
- `rst_ni` in 1: one clock; reset is asynchronous and active-low
- `req_valid_i` in 1: upstream request valid
- `req_ready_o` out 1: upstream request ready
- `req_i` in `ReqWidth`: request payload
- `lane_req_valid_o` out `NrLane`: per-lane request valid
- `lane_req_ready_i` in `NrLane`: per-lane request ready
- `lane_req_o` out `NrLane×ReqWidth`: per-lane request payload
- `lane_done_i` in `NrLane×NrVFU`: per-lane, per-VFU single-cycle done pulse
- `lane_done_id_i` in `NrLane×NrVFU×IdWidth`: ID accompanying each done pulse
- `done_o` out `NrVFU`: aggregated done pulse
- `done_id_o` out `NrVFU×IdWidth`: ID of the aggregated done (lane 0's ID)
- `overflow_o` out 1: sticky error, a done pulse arrived at a full counter

## Operation
Request path:
- `req_ready_o` = AND over lanes of (lane FIFO not full).
  - Derived from occupancy only; a same-cycle pop does not raise it.
- An accepted request (`req_valid_i & req_ready_o`) is pushed into every lane FIFO in the same cycle.
- Each lane pops independently. `lane_req_valid_o[l]` = FIFO l not empty, and `lane_req_o[l]` = FIFO l head.
  - The head pops on `lane_req_valid_o[l] & lane_req_ready_i[l]`.
- There is no bypass: a pushed entry becomes visible at the lane the cycle after acceptance.
- A simultaneous push and pop on a non-full FIFO keeps occupancy unchanged.
- Order is preserved per lane.

Done path, per VFU v:
- Each lane has a counter `cnt[v][l]` of width `$clog2(DoneDepth+1)`.
- Lane 0 additionally owns an ID FIFO of depth `DoneDepth`; its occupancy always equals `cnt[v][0]`.
- `done_o[v]` = AND over lanes of (`cnt[v][l] != 0`). This is combinational from registered counters.
- `done_id_o[v]` = lane 0 ID FIFO head when `done_o[v]` is high; otherwise `'0`.
- Each clock edge, `cnt[v][l]` changes by +1 for a `lane_done_i` pulse and −1 when `done_o[v]` is high.
  - Both events in the same cycle give a net change of 0.
  - The lane 0 ID FIFO pushes and pops correspondingly.
- Lanes report completions per VFU in the same order. IDs from lanes ≠ 0 are not stored.
- Overflow: a pulse arriving while `cnt[v][l]==DoneDepth` and `done_o[v]` is low is dropped, and `overflow_o` is set.
  - `overflow_o` clears only on reset.
  - A pulse arriving at a full counter while `done_o[v]` is high is not an overflow.

## Timing
- Reset (async assert, sync deassert by the environment): all FIFOs empty, all counters 0, `overflow_o`=0.
  - Outputs during and after reset: `req_ready_o`=1, `lane_req_valid_o`=0, `lane_req_o`='0, `done_o`=0, `done_id_o`='0.
- Request latency: accept at cycle N → `lane_req_valid_o` high at N+1 for every lane whose FIFO was empty.
- Throughput: 1 request/cycle while all lanes pop every cycle.
  - With `FifoDepth`=2 and a lane that pops only every other cycle, sustained throughput is 1 request per 2 cycles.
- Done latency: the last lane's pulse is sampled at edge N → `done_o[v]` is high for exactly the cycle following edge N.
  - Each `done_o[v]` pulse lasts one cycle per matched set. Back-to-back sets give back-to-back pulses.
- Reset mid-operation discards all queued requests and pending counts immediately.

## Test plan
- NrLane=4, all lanes ready: issue IDs 0..7 back-to-back → each lane receives 0..7 in order, each entry 1 cycle after acceptance, and `req_ready_o` never drops.
- Lane 2 holds `lane_req_ready_i`=0: after 2 accepts (`FifoDepth`=2), `req_ready_o` drops. Lanes 0, 1 and 3 still drain both entries. Releasing lane 2 → `req_ready_o` high the cycle after its first pop.
- VFU 1 pulses from lanes 0, 1, 2, 3 on cycles 0, 3, 5, 9, with lane 0 ID=5 → single `done_o[1]` pulse at cycle 10 with `done_id_o[1]`=5. No pulse earlier.
- Lane 0 pulses VFU 0 twice (IDs 2, 3) before the other lanes, then lanes 1-3 pulse twice simultaneously → two consecutive `done_o[0]` pulses with IDs 2 then 3.
- `DoneDepth`=4: lane 3 pulses VFU 2 five times while the other lanes are silent → `overflow_o` rises after the 5th pulse. Four later matched sets yield exactly 4 `done_o[2]` pulses.
- Assert `rst_ni` low with 2 queued requests and pending counts → all outputs return to reset values asynchronously, and no stale `done_o` pulses follow after release.

Source files
------------

// File: rtl/lane_dispatch_sync.sv
// -----------------------------------------------------------------------------
// lane_dispatch_sync
//
// Request-broadcast and completion-synchronisation hub between the vector
// instruction launcher and NrLane lanes.
//
// Request path: an accepted upstream request goes into every per-lane skid
// FIFO in the same cycle. Each lane then drains its own FIFO on its own
// schedule, so one stalled lane does not stall the others until its FIFO
// fills.
//
// Done path: for each VFU, every lane keeps a count of done pulses that have
// not been matched yet. When every lane has at least one pending pulse, one
// aggregated done pulse is released and each count drops by one. Only lane 0
// stores IDs. Its ID FIFO always holds exactly cnt[v][0] entries.
//
// Ports
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   req_valid_i/ready_o upstream request handshake, payload req_i
//   lane_req_valid_o    per-lane request valid (FIFO not empty)
//   lane_req_ready_i    per-lane request ready (pops the FIFO head)
//   lane_req_o          per-lane FIFO head ('0 when empty)
//   lane_done_i         per-lane, per-VFU single-cycle done pulse
//   lane_done_id_i      ID sent with each done pulse (only lane 0 is used)
//   done_o              aggregated per-VFU done pulse
//   done_id_o           lane 0 ID of the aggregated done ('0 when idle)
//   overflow_o          sticky: a done pulse was dropped at a full counter
// -----------------------------------------------------------------------------
module lane_dispatch_sync #(
  parameter int NrLane    = 4,
  parameter int FifoDepth = 2,
  parameter int ReqWidth  = 64,
  parameter int NrVFU     = 4,
  parameter int IdWidth   = 3,
  parameter int DoneDepth = 4
) (
  input  logic                                     clk_i,
  input  logic                                     rst_ni,
  input  logic                                     req_valid_i,
  output logic                                     req_ready_o,
  input  logic [ReqWidth-1:0]                      req_i,
  output logic [NrLane-1:0]                        lane_req_valid_o,
  input  logic [NrLane-1:0]                        lane_req_ready_i,
  output logic [NrLane-1:0][ReqWidth-1:0]          lane_req_o,
  input  logic [NrLane-1:0][NrVFU-1:0]             lane_done_i,
  input  logic [NrLane-1:0][NrVFU-1:0][IdWidth-1:0] lane_done_id_i,
  output logic [NrVFU-1:0]                         done_o,
  output logic [NrVFU-1:0][IdWidth-1:0]            done_id_o,
  output logic                                     overflow_o
);

  // ---------------------------------------------------------------------------
  // Sizing
  // ---------------------------------------------------------------------------
  localparam int AW = $clog2(FifoDepth);                       // request FIFO index
  localparam int CW = $clog2(DoneDepth + 1);                   // pending-count width
  localparam int DW = (DoneDepth > 1) ? $clog2(DoneDepth) : 1; // ID FIFO index

  // The pointers carry one extra wrap bit. The FIFO is full when the index
  // bits match and the wrap bits differ.
  localparam logic [AW:0]   FullDiff = {1'b1, {AW{1'b0}}};
  localparam logic [CW-1:0] CntMax   = CW'(DoneDepth);

  // ---------------------------------------------------------------------------
  // Request path state
  // ---------------------------------------------------------------------------
  logic [NrLane-1:0][AW:0] wr_ptr_q, wr_ptr_d;
  logic [NrLane-1:0][AW:0] rd_ptr_q, rd_ptr_d;
  logic [ReqWidth-1:0]     mem_q [NrLane][FifoDepth];

  logic [NrLane-1:0] fifo_empty;
  logic [NrLane-1:0] fifo_full;
  logic [NrLane-1:0] lane_pop;
  logic              req_push;

  // ---------------------------------------------------------------------------
  // Done path state
  // ---------------------------------------------------------------------------
  logic [NrVFU-1:0][NrLane-1:0][CW-1:0] cnt_q, cnt_d;
  logic [IdWidth-1:0]                   id_mem_q [NrVFU][DoneDepth];
  logic [NrVFU-1:0][DW-1:0]             id_wr_q, id_wr_d;
  logic [NrVFU-1:0][DW-1:0]             id_rd_q, id_rd_d;
  logic [NrVFU-1:0][NrLane-1:0]         lane_accept;
  logic                                 overflow_q, overflow_d;

  // The ID FIFO depth need not be a power of two, so its pointers wrap
  // explicitly.
  function automatic logic [DW-1:0] wrap_inc(input logic [DW-1:0] p);
    if (p == DW'(DoneDepth - 1)) return '0;
    else                         return p + DW'(1);
  endfunction

  // ---------------------------------------------------------------------------
  // Request FIFO status. It comes from registered pointers only, so a pop in
  // the same cycle does not raise req_ready_o.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: each output gets a default before the loop, so every path assigns it and no latch is inferred.
    fifo_empty = '0;
    fifo_full  = '0;
    for (int l = 0; l < NrLane; l++) begin
      fifo_empty[l] = (wr_ptr_q[l] == rd_ptr_q[l]);
      fifo_full[l]  = ((wr_ptr_q[l] ^ rd_ptr_q[l]) == FullDiff);
    end
  end

  always_comb begin
    req_ready_o      = ~|fifo_full;
    req_push         = req_valid_i & ~|fifo_full;
    lane_req_valid_o = ~fifo_empty;
    lane_pop         = ~fifo_empty & lane_req_ready_i;
  end

  // The head is gated by valid, so storage that was never reset does not
  // show at the outputs.
  always_comb begin
    lane_req_o = '0;
    for (int l = 0; l < NrLane; l++) begin
      if (!fifo_empty[l]) lane_req_o[l] = mem_q[l][rd_ptr_q[l][AW-1:0]];
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    for (int l = 0; l < NrLane; l++) begin
      if (req_push)    wr_ptr_d[l] = wr_ptr_q[l] + (AW+1)'(1);
      if (lane_pop[l]) rd_ptr_d[l] = rd_ptr_q[l] + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: sequential state uses non-blocking assignment, so every flop samples pre-edge values.
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: payload storage has no reset. Empty FIFOs gate their outputs, so reset only needs the pointers.
  always_ff @(posedge clk_i) begin
    for (int l = 0; l < NrLane; l++) begin
      if (req_push) mem_q[l][wr_ptr_q[l][AW-1:0]] <= req_i;
    end
  end

  // ---------------------------------------------------------------------------
  // Done aggregation
  // ---------------------------------------------------------------------------
  always_comb begin
    done_o = '1;
    for (int v = 0; v < NrVFU; v++) begin
      for (int l = 0; l < NrLane; l++) begin
        if (cnt_q[v][l] == '0) done_o[v] = 1'b0;
      end
    end
  end

  always_comb begin
    done_id_o = '0;
    for (int v = 0; v < NrVFU; v++) begin
      if (done_o[v]) done_id_o[v] = id_mem_q[v][id_rd_q[v]];
    end
  end

  // A pulse is taken unless the counter is full and nothing drains it this
  // cycle. A full counter with done high absorbs the pulse with a net change
  // of zero.
  always_comb begin
    lane_accept = '0;
    for (int v = 0; v < NrVFU; v++) begin
      for (int l = 0; l < NrLane; l++) begin
        lane_accept[v][l] = lane_done_i[l][v] & ((cnt_q[v][l] != CntMax) | done_o[v]);
      end
    end
  end

  always_comb begin
    cnt_d      = cnt_q;
    overflow_d = overflow_q;
    for (int v = 0; v < NrVFU; v++) begin
      for (int l = 0; l < NrLane; l++) begin
        if (lane_accept[v][l] && !done_o[v])      cnt_d[v][l] = cnt_q[v][l] + CW'(1);
        else if (!lane_accept[v][l] && done_o[v]) cnt_d[v][l] = cnt_q[v][l] - CW'(1);
        if (lane_done_i[l][v] && !lane_accept[v][l]) overflow_d = 1'b1;
      end
    end
  end

  // The lane 0 ID FIFO moves in step with cnt[v][0]. It pushes on an accepted
  // lane 0 pulse and pops on each aggregated done.
  always_comb begin
    id_wr_d = id_wr_q;
    id_rd_d = id_rd_q;
    for (int v = 0; v < NrVFU; v++) begin
      if (lane_accept[v][0]) id_wr_d[v] = wrap_inc(id_wr_q[v]);
      if (done_o[v])         id_rd_d[v] = wrap_inc(id_rd_q[v]);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q      <= '0;
      id_wr_q    <= '0;
      id_rd_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      id_wr_q    <= id_wr_d;
      id_rd_q    <= id_rd_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk_i) begin
    for (int v = 0; v < NrVFU; v++) begin
      if (lane_accept[v][0]) id_mem_q[v][id_wr_q[v]] <= lane_done_id_i[0][v];
    end
  end

  assign overflow_o = overflow_q;

  // Lanes other than lane 0 report IDs that are never stored. Folding them
  // here records that they are deliberately unused.
  logic unused_done_ids;
  assign unused_done_ids = ^lane_done_id_i;

endmodule

// File: tb/tb_lane_dispatch_sync.sv
// -----------------------------------------------------------------------------
// tb_lane_dispatch_sync
//
// Self-checking bench for lane_dispatch_sync. A behavioural model keeps
// per-lane request queues, per-VFU pending counts as integers, and a queue of
// lane 0 IDs. Every cycle all DUT outputs are compared with the model on the
// falling edge. Directed scenarios come first, then randomized traffic.
// -----------------------------------------------------------------------------
module tb_lane_dispatch_sync;

  localparam int NrLane    = 4;
  localparam int FifoDepth = 2;
  localparam int ReqWidth  = 64;
  localparam int NrVFU     = 4;
  localparam int IdWidth   = 3;
  localparam int DoneDepth = 4;

  logic                                      clk_i = 1'b0;
  logic                                      rst_ni = 1'b0;
  logic                                      req_valid_i;
  logic                                      req_ready_o;
  logic [ReqWidth-1:0]                       req_i;
  logic [NrLane-1:0]                         lane_req_valid_o;
  logic [NrLane-1:0]                         lane_req_ready_i;
  logic [NrLane-1:0][ReqWidth-1:0]           lane_req_o;
  logic [NrLane-1:0][NrVFU-1:0]              lane_done_i;
  logic [NrLane-1:0][NrVFU-1:0][IdWidth-1:0] lane_done_id_i;
  logic [NrVFU-1:0]                          done_o;
  logic [NrVFU-1:0][IdWidth-1:0]             done_id_o;
  logic                                      overflow_o;

  lane_dispatch_sync #(
    .NrLane(NrLane), .FifoDepth(FifoDepth), .ReqWidth(ReqWidth),
    .NrVFU(NrVFU), .IdWidth(IdWidth), .DoneDepth(DoneDepth)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_i(req_i),
    .lane_req_valid_o(lane_req_valid_o), .lane_req_ready_i(lane_req_ready_i),
    .lane_req_o(lane_req_o),
    .lane_done_i(lane_done_i), .lane_done_id_i(lane_done_id_i),
    .done_o(done_o), .done_id_o(done_id_o), .overflow_o(overflow_o)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model
  logic [ReqWidth-1:0] mq   [NrLane][$];
  int                  mcnt [NrVFU][NrLane];
  logic [IdWidth-1:0]  mid  [NrVFU][$];
  bit                  movf;

  // Aggregated-done tally, used by the directed scenarios
  int                  done_seen    [NrVFU];
  logic [IdWidth-1:0]  last_done_id [NrVFU];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_ready();
    for (int l = 0; l < NrLane; l++) if (mq[l].size() >= FifoDepth) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit m_done(input int v);
    for (int l = 0; l < NrLane; l++) if (mcnt[v][l] == 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    for (int l = 0; l < NrLane; l++) mq[l].delete();
    for (int v = 0; v < NrVFU; v++) begin
      mid[v].delete();
      for (int l = 0; l < NrLane; l++) mcnt[v][l] = 0;
    end
    movf = 1'b0;
  endtask

  task automatic clear_tally();
    for (int v = 0; v < NrVFU; v++) begin
      done_seen[v]    = 0;
      last_done_id[v] = '0;
    end
  endtask

  task automatic compare_all();
    logic [63:0] exp;
    check("req_ready", 64'(req_ready_o), 64'(m_ready()));
    for (int l = 0; l < NrLane; l++) begin
      check($sformatf("lane_valid[%0d]", l), 64'(lane_req_valid_o[l]), 64'(mq[l].size() != 0));
      exp = (mq[l].size() != 0) ? 64'(mq[l][0]) : 64'd0;
      check($sformatf("lane_req[%0d]", l), 64'(lane_req_o[l]), exp);
    end
    for (int v = 0; v < NrVFU; v++) begin
      check($sformatf("done[%0d]", v), 64'(done_o[v]), 64'(m_done(v)));
      exp = m_done(v) ? 64'(mid[v][0]) : 64'd0;
      check($sformatf("done_id[%0d]", v), 64'(done_id_o[v]), exp);
      if (done_o[v]) begin
        done_seen[v]++;
        last_done_id[v] = done_id_o[v];
      end
    end
    check("overflow", 64'(overflow_o), 64'(movf));
  endtask

  // Apply one clock edge to the model, using the inputs driven this cycle.
  task automatic model_advance();
    bit acc;
    bit d [NrVFU];
    if (!rst_ni) return;
    acc = req_valid_i && m_ready();
    for (int v = 0; v < NrVFU; v++) d[v] = m_done(v);
    for (int l = 0; l < NrLane; l++) begin
      if (mq[l].size() != 0 && lane_req_ready_i[l]) void'(mq[l].pop_front());
      if (acc) mq[l].push_back(req_i);
    end
    for (int v = 0; v < NrVFU; v++) begin
      if (d[v]) void'(mid[v].pop_front());
      for (int l = 0; l < NrLane; l++) begin
        if (lane_done_i[l][v]) begin
          if (mcnt[v][l] == DoneDepth && !d[v]) movf = 1'b1;
          else begin
            mcnt[v][l]++;
            if (l == 0) mid[v].push_back(lane_done_id_i[0][v]);
          end
        end
        if (d[v]) mcnt[v][l]--;
      end
    end
  endtask

  // One cycle: inputs are set at posedge+1, checked at the falling edge, and
  // the model advances before the next rising edge.
  task automatic cycle();
    @(negedge clk_i);
    compare_all();
    model_advance();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    req_valid_i      = 1'b0;
    req_i            = '0;
    lane_req_ready_i = '1;
    lane_done_i      = '0;
    lane_done_id_i   = '0;
  endtask

  initial begin
    idle();
    model_reset();
    clear_tally();
    rst_ni = 1'b0;
    repeat (3) cycle();
    rst_ni = 1'b1;
    cycle();

    // Back-to-back requests with every lane ready
    for (int i = 0; i < 8; i++) begin
      req_valid_i = 1'b1;
      req_i       = 64'(i);
      cycle();
    end
    idle();
    repeat (3) cycle();

    // Lane 2 stalls, so the upstream stalls after FifoDepth accepts
    lane_req_ready_i = 4'b1011;
    req_valid_i      = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_i = 64'(100 + i);
      cycle();
    end
    check("stall_ready_low", 64'(req_ready_o), 64'd0);
    req_valid_i      = 1'b0;
    lane_req_ready_i = '1;
    repeat (4) cycle();

    // VFU 1: lanes 0..3 report on cycles 0, 3, 5 and 9
    clear_tally();
    for (int c = 0; c < 12; c++) begin
      idle();
      if (c == 0) begin lane_done_i[0][1] = 1'b1; lane_done_id_i[0][1] = 3'd5; end
      if (c == 3) lane_done_i[1][1] = 1'b1;
      if (c == 5) lane_done_i[2][1] = 1'b1;
      if (c == 9) lane_done_i[3][1] = 1'b1;
      cycle();
    end
    check("skew_done_count", 64'(done_seen[1]), 64'd1);
    check("skew_done_id", 64'(last_done_id[1]), 64'd5);

    // VFU 0: lane 0 runs two ahead, then the others report twice together
    clear_tally();
    for (int c = 0; c < 7; c++) begin
      idle();
      if (c == 0) begin lane_done_i[0][0] = 1'b1; lane_done_id_i[0][0] = 3'd2; end
      if (c == 1) begin lane_done_i[0][0] = 1'b1; lane_done_id_i[0][0] = 3'd3; end
      if (c == 2 || c == 3) for (int l = 1; l < NrLane; l++) lane_done_i[l][0] = 1'b1;
      cycle();
    end
    check("b2b_done_count", 64'(done_seen[0]), 64'd2);
    check("b2b_last_id", 64'(last_done_id[0]), 64'd3);

    // VFU 2: lane 3 sends one pulse more than DoneDepth
    clear_tally();
    for (int c = 0; c < 5; c++) begin
      idle();
      lane_done_i[3][2] = 1'b1;
      cycle();
    end
    idle();
    cycle();
    check("overflow_set", 64'(overflow_o), 64'd1);
    for (int c = 0; c < 4; c++) begin
      idle();
      for (int l = 0; l < 3; l++) begin
        lane_done_i[l][2]    = 1'b1;
        lane_done_id_i[l][2] = 3'(c + 4);
      end
      cycle();
    end
    idle();
    repeat (4) cycle();
    check("overflow_done_count", 64'(done_seen[2]), 64'd4);
    check("overflow_sticky", 64'(overflow_o), 64'd1);

    // Reset in the middle of operation
    lane_req_ready_i = '0;
    req_valid_i      = 1'b1;
    req_i            = 64'hA5;
    cycle();
    req_i = 64'h5A;
    lane_done_i[0][3] = 1'b1;
    lane_done_i[1][3] = 1'b1;
    cycle();
    idle();
    lane_req_ready_i = '0;
    #2;
    rst_ni = 1'b0;
    #1;
    check("rst_ready", 64'(req_ready_o), 64'd1);
    check("rst_valid", 64'(lane_req_valid_o), 64'd0);
    for (int l = 0; l < NrLane; l++) check($sformatf("rst_lane_req[%0d]", l), 64'(lane_req_o[l]), 64'd0);
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_done_id", 64'(done_id_o), 64'd0);
    check("rst_overflow", 64'(overflow_o), 64'd0);
    model_reset();
    repeat (2) cycle();
    rst_ni = 1'b1;
    clear_tally();
    idle();
    repeat (3) cycle();
    for (int l = 0; l < NrLane; l++) lane_done_i[l][3] = 1'b1;
    cycle();
    idle();
    repeat (2) cycle();
    check("post_rst_single_done", 64'(done_seen[3]), 64'd1);

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      req_valid_i      = ($urandom_range(0, 3) != 0);
      req_i            = {$urandom, $urandom};
      lane_req_ready_i = NrLane'($urandom);
      lane_req_ready_i = lane_req_ready_i | NrLane'($urandom);
      for (int l = 0; l < NrLane; l++) begin
        for (int v = 0; v < NrVFU; v++) begin
          lane_done_i[l][v]    = ($urandom_range(0, 3) == 0);
          lane_done_id_i[l][v] = IdWidth'($urandom);
        end
      end
      if (c == 2000) begin
        #2;
        rst_ni = 1'b0;
        model_reset();
      end
      if (c == 2003) rst_ni = 1'b1;
      cycle();
    end
    idle();
    repeat (4) cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
